// File: rtl/alt_ddrx_reset_sequencer.sv
// Purpose : holds controller sub-blocks in reset until PHY calibration has passed
//           and held for a settling period, then releases per-stage resets in index
//           order and raises ctl_ready; drops back on calibration loss or failure.
// Latency : all outputs registered; with success first sampled at edge E0, stage k
//           releases at E0+STABLE_CYCLES+(k+1)*STAGE_GAP and ctl_ready rises with the last stage.
// Backpressure: none; calibration inputs are levels, soft reset is a one-cycle pulse.
//
// Ports:
//   ctl_clk, ctl_reset        controller clock, synchronous active-high reset
//   ctl_cal_success/_fail     PHY calibration status levels
//   local_soft_reset_req      one-cycle request to restart the init sequence
//   ctl_stage_reset_n         per-stage active-low resets (bit k -> stage k)
//   ctl_ready                 all stages released
//   ctl_init_fail             sticky calibration failure flag
//   ctl_init_state            FSM state encoding for debug
module alt_ddrx_reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int STABLE_CYCLES = 16,
    parameter int STAGE_GAP     = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                  ctl_clk,
    input  logic                  ctl_reset,
    input  logic                  ctl_cal_success,
    input  logic                  ctl_cal_fail,
    input  logic                  local_soft_reset_req,
    output logic [NUM_STAGES-1:0] ctl_stage_reset_n,
    output logic                  ctl_ready,
    output logic                  ctl_init_fail,
    output logic [2:0]            ctl_init_state
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_CAL  = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    state_t                r_state,       w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt,         w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx,         w_idx_nxt;
    logic [NUM_STAGES-1:0] r_stage_rst_n, w_stage_rst_n_nxt;
    logic                  r_ready,       w_ready_nxt;
    logic                  r_init_fail,   w_init_fail_nxt;

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage_rst_n <= '0;
            r_ready       <= 1'b0;
            r_init_fail   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_stage_rst_n <= w_stage_rst_n_nxt;
            r_ready       <= w_ready_nxt;
            r_init_fail   <= w_init_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_idx_nxt         = r_idx;
        w_stage_rst_n_nxt = r_stage_rst_n;
        w_ready_nxt       = r_ready;
        w_init_fail_nxt   = r_init_fail;

        // Soft reset outranks everything; it is meaningless in IDLE, which is
        // already the restart point.
        if (local_soft_reset_req && (r_state != ST_IDLE)) begin
            w_state_nxt       = ST_IDLE;
            w_cnt_nxt         = '0;
            w_idx_nxt         = '0;
            w_stage_rst_n_nxt = '0;
            w_ready_nxt       = 1'b0;
            w_init_fail_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt       = ST_WAIT_CAL;
                    w_cnt_nxt         = '0;
                    w_idx_nxt         = '0;
                    w_stage_rst_n_nxt = '0;
                    w_ready_nxt       = 1'b0;
                end
                ST_WAIT_CAL: begin
                    if (ctl_cal_fail) begin
                        w_state_nxt     = ST_FAIL;
                        w_init_fail_nxt = 1'b1;
                    end else if (ctl_cal_success) begin
                        w_state_nxt = ST_STABILIZE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_STABILIZE: begin
                    if (ctl_cal_fail) begin
                        w_state_nxt     = ST_FAIL;
                        w_cnt_nxt       = '0;
                        w_init_fail_nxt = 1'b1;
                    end else if (!ctl_cal_success) begin
                        w_state_nxt = ST_WAIT_CAL;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_WIDTH'(STABLE_CYCLES - 1)) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_RELEASE, ST_READY: begin
                    if (ctl_cal_fail) begin
                        w_state_nxt       = ST_FAIL;
                        w_cnt_nxt         = '0;
                        w_idx_nxt         = '0;
                        w_stage_rst_n_nxt = '0;
                        w_ready_nxt       = 1'b0;
                        w_init_fail_nxt   = 1'b1;
                    end else if (!ctl_cal_success) begin
                        w_state_nxt       = ST_IDLE;
                        w_cnt_nxt         = '0;
                        w_idx_nxt         = '0;
                        w_stage_rst_n_nxt = '0;
                        w_ready_nxt       = 1'b0;
                    end else if (r_state == ST_RELEASE) begin
                        if (r_cnt == CNT_WIDTH'(STAGE_GAP - 1)) begin
                            w_stage_rst_n_nxt[r_idx] = 1'b1;
                            w_cnt_nxt                = '0;
                            // Last stage: ready rises on the same edge as its release.
                            if (r_idx == IDX_W'(NUM_STAGES - 1)) begin
                                w_state_nxt = ST_READY;
                                w_ready_nxt = 1'b1;
                            end else begin
                                w_idx_nxt = r_idx + IDX_W'(1);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_FAIL: begin
                    // Parked until soft reset or ctl_reset.
                    w_stage_rst_n_nxt = '0;
                    w_ready_nxt       = 1'b0;
                    w_init_fail_nxt   = 1'b1;
                end
                default: begin
                    w_state_nxt       = ST_IDLE;
                    w_cnt_nxt         = '0;
                    w_idx_nxt         = '0;
                    w_stage_rst_n_nxt = '0;
                    w_ready_nxt       = 1'b0;
                end
            endcase
        end
    end

    assign ctl_stage_reset_n = r_stage_rst_n;
    assign ctl_ready         = r_ready;
    assign ctl_init_fail     = r_init_fail;
    assign ctl_init_state    = r_state;

endmodule

// File: tb/tb_alt_ddrx_reset_sequencer.sv
// Purpose : directed bench for alt_ddrx_reset_sequencer with default parameters.
// Latency : edges are counted from E0, the first edge sampling ctl_cal_success high.
// Backpressure: n/a; outputs sampled 1 time unit after each rising edge.
module tb_alt_ddrx_reset_sequencer;

    logic       ctl_clk = 1'b0;
    logic       ctl_reset;
    logic       ctl_cal_success;
    logic       ctl_cal_fail;
    logic       local_soft_reset_req;
    logic [2:0] ctl_stage_reset_n;
    logic       ctl_ready;
    logic       ctl_init_fail;
    logic [2:0] ctl_init_state;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    alt_ddrx_reset_sequencer #(
        .NUM_STAGES   (3),
        .STABLE_CYCLES(16),
        .STAGE_GAP    (4),
        .CNT_WIDTH    (8)
    ) dut (
        .ctl_clk             (ctl_clk),
        .ctl_reset           (ctl_reset),
        .ctl_cal_success     (ctl_cal_success),
        .ctl_cal_fail        (ctl_cal_fail),
        .local_soft_reset_req(local_soft_reset_req),
        .ctl_stage_reset_n   (ctl_stage_reset_n),
        .ctl_ready           (ctl_ready),
        .ctl_init_fail       (ctl_init_fail),
        .ctl_init_state      (ctl_init_state)
    );

    always #5 ctl_clk = ~ctl_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=E%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step();
        @(posedge ctl_clk);
        #1;
        t++;
    endtask

    task automatic go_to(input int e);
        while (t < e) step();
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic [2:0] stg,
                              input logic rdy, input logic fl);
        check({tag, ".state"}, 32'(ctl_init_state), 32'(st));
        check({tag, ".stage"}, 32'(ctl_stage_reset_n), 32'(stg));
        check({tag, ".ready"}, 32'(ctl_ready), 32'(rdy));
        check({tag, ".fail"},  32'(ctl_init_fail), 32'(fl));
    endtask

    // Reset, then one edge in IDLE; ends in WAIT_CAL.
    task automatic reset_dut();
        ctl_reset            = 1'b1;
        ctl_cal_success      = 1'b0;
        ctl_cal_fail         = 1'b0;
        local_soft_reset_req = 1'b0;
        step();
        step();
        check_outs("rst", 3'd0, 3'b000, 1'b0, 1'b0);
        ctl_reset = 1'b0;
        step();
        check("rst.wait_cal", 32'(ctl_init_state), 32'd1);
    endtask

    // Success sampled high on the next edge, which becomes E0.
    task automatic start_e0();
        ctl_cal_success = 1'b1;
        step();
        t = 0;
        check("e0.state", 32'(ctl_init_state), 32'd2);
    endtask

    task automatic hold_fail_then_soft(input string tag);
        for (int i = 0; i < 50; i++) begin
            step();
            check({tag, ".hold_state"}, 32'(ctl_init_state), 32'd5);
        end
        check_outs({tag, ".held"}, 3'd5, 3'b000, 1'b0, 1'b1);
        local_soft_reset_req = 1'b1;
        step();
        local_soft_reset_req = 1'b0;
        check_outs({tag, ".soft"}, 3'd0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        // Full release sequence.
        reset_dut();
        start_e0();
        go_to(15); check_outs("t1.e15", 3'd2, 3'b000, 1'b0, 1'b0);
        go_to(16); check("t1.e16.state", 32'(ctl_init_state), 32'd3);
        go_to(19); check("t1.e19.stage", 32'(ctl_stage_reset_n), 32'b000);
        go_to(20); check_outs("t1.e20", 3'd3, 3'b001, 1'b0, 1'b0);
        go_to(23); check("t1.e23.stage", 32'(ctl_stage_reset_n), 32'b001);
        go_to(24); check_outs("t1.e24", 3'd3, 3'b011, 1'b0, 1'b0);
        go_to(27); check_outs("t1.e27", 3'd3, 3'b011, 1'b0, 1'b0);
        go_to(28); check_outs("t1.e28", 3'd4, 3'b111, 1'b1, 1'b0);

        // Drop success in READY, then rerun the full sequence.
        ctl_cal_success = 1'b0;
        step(); check_outs("t5.drop", 3'd0, 3'b000, 1'b0, 1'b0);
        step(); check("t5.wait", 32'(ctl_init_state), 32'd1);
        start_e0();
        go_to(19); check("t5.e19.stage", 32'(ctl_stage_reset_n), 32'b000);
        go_to(20); check("t5.e20.stage", 32'(ctl_stage_reset_n), 32'b001);
        go_to(28); check_outs("t5.e28", 3'd4, 3'b111, 1'b1, 1'b0);

        // Soft reset together with cal_fail in READY: soft reset wins.
        local_soft_reset_req = 1'b1;
        ctl_cal_fail         = 1'b1;
        step();
        local_soft_reset_req = 1'b0;
        ctl_cal_fail         = 1'b0;
        check_outs("t4.soft", 3'd0, 3'b000, 1'b0, 1'b0);
        step(); check("t4.wait", 32'(ctl_init_state), 32'd1);
        start_e0();
        go_to(28); check_outs("t4.e28", 3'd4, 3'b111, 1'b1, 1'b0);

        // Short success pulse, one-cycle dropout, restart of the stabilise count.
        reset_dut();
        start_e0();
        go_to(9);
        ctl_cal_success = 1'b0;
        go_to(10); check_outs("t2.drop", 3'd1, 3'b000, 1'b0, 1'b0);
        start_e0();
        go_to(16); check("t2.e16.state", 32'(ctl_init_state), 32'd3);
        go_to(19); check("t2.e19.stage", 32'(ctl_stage_reset_n), 32'b000);
        go_to(20); check("t2.e20.stage", 32'(ctl_stage_reset_n), 32'b001);

        // cal_fail in WAIT_CAL (success also high: fail has priority).
        reset_dut();
        ctl_cal_fail    = 1'b1;
        ctl_cal_success = 1'b1;
        step();
        ctl_cal_fail = 1'b0;
        check_outs("t3a.fail", 3'd5, 3'b000, 1'b0, 1'b1);
        hold_fail_then_soft("t3a");

        // cal_fail sampled at E22, after stage 0 released.
        reset_dut();
        start_e0();
        go_to(21); check("t3b.e21.stage", 32'(ctl_stage_reset_n), 32'b001);
        ctl_cal_fail = 1'b1;
        go_to(22);
        ctl_cal_fail = 1'b0;
        check_outs("t3b.e22", 3'd5, 3'b000, 1'b0, 1'b1);
        hold_fail_then_soft("t3b");

        // ctl_reset sampled at E25 with two stages released.
        reset_dut();
        start_e0();
        go_to(24); check("t6.e24.stage", 32'(ctl_stage_reset_n), 32'b011);
        ctl_reset = 1'b1;
        go_to(25);
        check_outs("t6.e25", 3'd0, 3'b000, 1'b0, 1'b0);
        ctl_reset = 1'b0;

        // Soft reset in IDLE is ignored: IDLE still advances to WAIT_CAL.
        ctl_reset = 1'b1;
        step();
        ctl_reset            = 1'b0;
        local_soft_reset_req = 1'b1;
        step();
        local_soft_reset_req = 1'b0;
        check("t7.idle_soft", 32'(ctl_init_state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
